// File: rtl/priority_encoder.sv
// Registered MSB-first priority encoder: index of the highest set request bit,
// plus a valid flag that separates "no request" from "bit 0 set".
module priority_encoder #(
    parameter int IP_WIDTH = 4,
    localparam int OP_WIDTH = $clog2(IP_WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [IP_WIDTH-1:0] i,
    output logic [OP_WIDTH-1:0] y,
    output logic                valid
);

    logic [OP_WIDTH-1:0] w_idx;
    logic                w_any;
    logic [OP_WIDTH-1:0] r_y;
    logic                r_valid;

    // Ascending scan: the last set bit written wins, so the MSB takes priority.
    always_comb begin
        w_idx = '0;
        w_any = 1'b0;
        for (int k = 0; k < IP_WIDTH; k++) begin
            if (i[k]) begin
                w_idx = OP_WIDTH'(k);
                w_any = 1'b1;
            end
        end
    end

    // en is tested before i is used, so an unknown i while disabled stays out of the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            if (w_any) begin
                r_y     <= w_idx;
                r_valid <= 1'b1;
            end else begin
                r_y     <= '0;
                r_valid <= 1'b0;
            end
        end else begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench: a 4-bit and a 5-bit encoder driven side by side against an
// arithmetic reference model (index = floor(log2(i))).
module tb_priority_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en4;
    logic [3:0] i4;
    logic [1:0] y4;
    logic       v4;
    logic       en5;
    logic [4:0] i5;
    logic [2:0] y5;
    logic       v5;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry packs {valid5, y5[2:0], valid4, y4[2:0]} for one clock edge.
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    priority_encoder #(.IP_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .i(i4), .y(y4), .valid(v4)
    );

    priority_encoder #(.IP_WIDTH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .en(en5), .i(i5), .y(y5), .valid(v5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {valid, index[2:0]}; index = floor(log2(v)) by halving.
    function automatic logic [3:0] model(input logic e, input logic [31:0] a);
        int unsigned v;
        int unsigned k;
        if (e !== 1'b1) return 4'd0;
        v = a;
        if (v == 0) return 4'd0;
        k = 0;
        while (v > 1) begin
            v = v / 2;
            k++;
        end
        return {1'b1, 3'(k)};
    endfunction

    task automatic check_outputs(input string tag, input logic [7:0] e);
        check({tag, "_y4"}, 32'(y4), 32'(e[2:0]));
        check({tag, "_v4"}, 32'(v4), 32'(e[3]));
        check({tag, "_y5"}, 32'(y5), 32'(e[6:4]));
        check({tag, "_v5"}, 32'(v5), 32'(e[7]));
    endtask

    task automatic cycle(input string tag, input logic e4, input logic [3:0] a4,
                         input logic e5, input logic [4:0] a5);
        logic [7:0] e;
        @(negedge clk);
        en4 = e4;
        i4  = a4;
        en5 = e5;
        i5  = a5;
        exp_q.push_back({model(e5, 32'(a5)), model(e4, 32'(a4))});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outputs(tag, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r4;
        logic [4:0] r5;

        // Reset held with live requests: outputs must stay zero across edges.
        rst_n = 1'b0;
        en4 = 1'b1; i4 = 4'b1000;
        en5 = 1'b1; i5 = 5'b10000;
        #1;
        check_outputs("reset_async", 8'h00);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outputs("reset_hold", 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("reset_release", {4'b1100, 4'b1011});

        for (int v = 0; v < 16; v++)
            cycle("en0_sweep", 1'b0, 4'(v), 1'b0, 5'(v + 16));

        for (int v = 0; v < 16; v++)
            cycle("en1_sweep4", 1'b1, 4'(v), 1'b0, 5'(v));
        for (int v = 0; v < 32; v++)
            cycle("en1_sweep5", 1'(v % 2), 4'(v), 1'b1, 5'(v));

        cycle("mask_0111", 1'b1, 4'b0111, 1'b1, 5'b00111);
        cycle("mask_1001", 1'b1, 4'b1001, 1'b1, 5'b10001);
        cycle("mask_0001", 1'b1, 4'b0001, 1'b1, 5'b00001);

        cycle("toggle_en1a", 1'b1, 4'b0100, 1'b1, 5'b00100);
        cycle("toggle_en0",  1'b0, 4'b0100, 1'b0, 5'b00100);
        cycle("toggle_en1b", 1'b1, 4'b0100, 1'b1, 5'b00100);

        // Inputs changed between edges must not disturb the registered outputs.
        #2;
        en4 = 1'b0; i4 = 4'b0001;
        en5 = 1'b1; i5 = 5'b11111;
        #1;
        check_outputs("between_edges", {4'b1010, 4'b1010});

        cycle("x_disabled", 1'b0, 4'bxxxx, 1'b0, 5'bxxxxx);

        for (int n = 0; n < 300; n++) begin
            r4 = 4'($urandom_range(0, 15));
            r5 = 5'($urandom_range(0, 31));
            cycle("random", 1'($urandom_range(0, 3) != 0), r4,
                  1'($urandom_range(0, 3) != 0), r5);
        end

        // Asynchronous reset asserted mid-cycle, well away from any clock edge.
        cycle("pre_reset", 1'b1, 4'b0010, 1'b1, 5'b10000);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs("reset_midrun", 8'h00);
        @(posedge clk);
        #1;
        check_outputs("reset_midrun_hold", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("resume", 1'b1, 4'b1010, 1'b1, 5'b01100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
